dma_write_upsizer: RTL and testbench

- Write-path stage between the narrow DMA slave port (32-bit, single-beat AXI writes) and the wide M00_AXI master (128-bit, 6-bit ID).
- Upsizes each write: replicates data across lanes and shifts strobes by the address.
- Allocates M00 IDs from an in-order ring, absorbs out-of-order B responses and returns DMA B responses strictly in issue order.
- Exports a credit count that the DMA credit-query read path reports.

---
 rtl/dma_pkg.sv | 34 +++
 rtl/dma_resp_scoreboard.sv | 95 +++++++++
 rtl/dma_write_upsizer.sv | 156 +++++++++++++++
 tb/tb_dma_write_upsizer.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared constants, types and helpers for the DMA write upsizer and its
// response scoreboard.
package dma_pkg;

  localparam int DMA_ADDR_W   = 49;
  localparam int DMA_NARROW_W = 32;
  localparam int DMA_WIDE_W   = 128;
  localparam int DMA_ID_W     = 6;
  localparam int DMA_MAX_OUT  = 16;
  localparam int DMA_NB       = DMA_NARROW_W / 8;
  localparam int DMA_WB       = DMA_WIDE_W / 8;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Number of narrow lanes packed into one wide beat.
  function automatic int lane_count(input int wide_w, input int narrow_w);
    return wide_w / narrow_w;
  endfunction

  typedef struct packed {
    logic [DMA_ADDR_W-1:0]   addr;
    logic [DMA_NARROW_W-1:0] data;
    logic [DMA_NB-1:0]       strb;
  } narrow_req_t;

  typedef struct packed {
    logic [DMA_WIDE_W-1:0] data;
    logic [DMA_WB-1:0]     strb;
    logic                  last;
  } wide_w_t;

endpackage

// File: rtl/dma_resp_scoreboard.sv
// In-order ID ring for outstanding M00 writes: absorbs out-of-order B
// responses and hands them back to the DMA port strictly in issue order.
module dma_resp_scoreboard
  import dma_pkg::*;
#(
  parameter int ID_W    = DMA_ID_W,
  parameter int MAX_OUT = DMA_MAX_OUT
) (
  input  logic                         clock,
  input  logic                         RESETn,
  input  logic                         alloc,
  output logic [$clog2(MAX_OUT)-1:0]   alloc_id,
  output logic [$clog2(MAX_OUT):0]     credits,
  input  logic [ID_W-1:0]              m_bid,
  input  logic [1:0]                   m_bresp,
  input  logic                         m_bvalid,
  output logic [1:0]                   s_bresp,
  output logic                         s_bvalid,
  input  logic                         s_bready,
  output logic                         err_unexp_b
);

  localparam int PTR_W = $clog2(MAX_OUT);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]   head_reg, tail_reg;
  logic [CNT_W-1:0]   credits_reg;
  logic [MAX_OUT-1:0] done_reg;
  logic [1:0]         bresp_reg [MAX_OUT];
  logic               err_reg;

  logic               retire, b_hit;
  logic [PTR_W-1:0]   b_slot, b_offset;
  logic [CNT_W-1:0]   outstanding;
  logic [MAX_OUT-1:0] set_vec, clr_vec;

  assign outstanding = CNT_W'(MAX_OUT) - credits_reg;
  assign b_slot      = m_bid[PTR_W-1:0];
  assign b_offset    = b_slot - head_reg;

  // An ID is live only if it lies in [head, tail) modulo the ring size.
  always_comb begin
    b_hit = 1'b0;
    if (m_bvalid && ((m_bid >> PTR_W) == '0))
      b_hit = ({1'b0, b_offset} < outstanding);
  end

  assign s_bvalid    = done_reg[head_reg];
  assign s_bresp     = bresp_reg[head_reg];
  assign retire      = s_bvalid && s_bready;
  assign alloc_id    = tail_reg;
  assign credits     = credits_reg;
  assign err_unexp_b = err_reg;

  // A repeated B for a slot already done is absorbed so s_bresp stays stable.
  for (genvar gi = 0; gi < MAX_OUT; gi++) begin : g_slot
    assign clr_vec[gi] = retire && (head_reg == PTR_W'(gi));
    assign set_vec[gi] = b_hit && (b_slot == PTR_W'(gi)) && !done_reg[gi];
  end

  always_ff @(posedge clock or negedge RESETn) begin
    if (!RESETn) begin
      done_reg <= '0;
      for (int i = 0; i < MAX_OUT; i++) bresp_reg[i] <= RESP_OKAY;
    end else begin
      for (int i = 0; i < MAX_OUT; i++) begin
        if (clr_vec[i]) begin
          done_reg[i] <= 1'b0;
        end else if (set_vec[i]) begin
          done_reg[i]  <= 1'b1;
          bresp_reg[i] <= m_bresp;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge RESETn) begin
    if (!RESETn) begin
      head_reg    <= '0;
      tail_reg    <= '0;
      credits_reg <= CNT_W'(MAX_OUT);
      err_reg     <= 1'b0;
    end else begin
      if (alloc)  tail_reg <= tail_reg + PTR_W'(1);
      if (retire) head_reg <= head_reg + PTR_W'(1);
      case ({alloc, retire})
        2'b10:   credits_reg <= credits_reg - CNT_W'(1);
        2'b01:   credits_reg <= credits_reg + CNT_W'(1);
        default: credits_reg <= credits_reg;
      endcase
      if (m_bvalid && !b_hit) err_reg <= 1'b1;
    end
  end

endmodule

// File: rtl/dma_write_upsizer.sv
// Captures single-beat narrow DMA writes, upsizes them onto the wide M00
// port and returns B responses in issue order via the response scoreboard.
module dma_write_upsizer
  import dma_pkg::*;
#(
  parameter int ADDR_W   = DMA_ADDR_W,
  parameter int NARROW_W = DMA_NARROW_W,
  parameter int WIDE_W   = DMA_WIDE_W,
  parameter int ID_W     = DMA_ID_W,
  parameter int MAX_OUT  = DMA_MAX_OUT
) (
  input  logic                       clock,
  input  logic                       RESETn,
  input  logic [ADDR_W-1:0]          s_awaddr,
  input  logic                       s_awvalid,
  output logic                       s_awready,
  input  logic [NARROW_W-1:0]        s_wdata,
  input  logic [NARROW_W/8-1:0]      s_wstrb,
  input  logic                       s_wvalid,
  output logic                       s_wready,
  output logic [1:0]                 s_bresp,
  output logic                       s_bvalid,
  input  logic                       s_bready,
  output logic [ID_W-1:0]            m_awid,
  output logic [ADDR_W-1:0]          m_awaddr,
  output logic [7:0]                 m_awlen,
  output logic [2:0]                 m_awsize,
  output logic [1:0]                 m_awburst,
  output logic                       m_awvalid,
  input  logic                       m_awready,
  output logic [WIDE_W-1:0]          m_wdata,
  output logic [WIDE_W/8-1:0]        m_wstrb,
  output logic                       m_wlast,
  output logic                       m_wvalid,
  input  logic                       m_wready,
  input  logic [ID_W-1:0]            m_bid,
  input  logic [1:0]                 m_bresp,
  input  logic                       m_bvalid,
  output logic                       m_bready,
  output logic [$clog2(MAX_OUT):0]   credits,
  output logic                       err_unexp_b
);

  localparam int NB     = NARROW_W / 8;
  localparam int WB     = WIDE_W / 8;
  localparam int LANES  = lane_count(WIDE_W, NARROW_W);
  localparam int NB_LG  = $clog2(NB);
  localparam int WB_LG  = $clog2(WB);
  localparam int PTR_W  = $clog2(MAX_OUT);

  narrow_req_t            req_reg;
  logic                   aw_held_reg, w_held_reg;
  logic                   awvalid_reg, wvalid_reg;
  logic [ID_W-1:0]        awid_reg;
  logic [ADDR_W-1:0]      awaddr_reg;
  wide_w_t                w_reg, w_next;

  logic                   alloc, issue_pending;
  logic [PTR_W-1:0]       alloc_id;
  logic [PTR_W:0]         credits_int;
  logic [WB_LG-NB_LG-1:0] lane;
  logic [WIDE_W-1:0]      wide_data;
  logic [WB-1:0]          wide_strb;

  assign s_awready     = !aw_held_reg;
  assign s_wready      = !w_held_reg;
  assign issue_pending = awvalid_reg || wvalid_reg;
  assign alloc         = aw_held_reg && w_held_reg && (credits_int != '0) && !issue_pending;

  // Narrow data goes to every lane; the strobe selects the addressed lane.
  assign lane = req_reg.addr[WB_LG-1:NB_LG];
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign wide_data[gi*NARROW_W +: NARROW_W] = req_reg.data;
  end
  assign wide_strb = WB'(req_reg.strb) << (NB * int'(lane));

  always_comb begin
    w_next      = '0;
    w_next.data = wide_data;
    w_next.strb = wide_strb;
    w_next.last = 1'b1;
  end

  always_ff @(posedge clock or negedge RESETn) begin
    if (!RESETn) begin
      aw_held_reg <= 1'b0;
      w_held_reg  <= 1'b0;
      req_reg     <= '0;
    end else if (alloc) begin
      aw_held_reg <= 1'b0;
      w_held_reg  <= 1'b0;
    end else begin
      if (s_awvalid && s_awready) begin
        aw_held_reg  <= 1'b1;
        req_reg.addr <= s_awaddr;
      end
      if (s_wvalid && s_wready) begin
        w_held_reg   <= 1'b1;
        req_reg.data <= s_wdata;
        req_reg.strb <= s_wstrb;
      end
    end
  end

  // AW and W retire independently; the issue stays pending until both have.
  always_ff @(posedge clock or negedge RESETn) begin
    if (!RESETn) begin
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      awid_reg    <= '0;
      awaddr_reg  <= '0;
      w_reg       <= '0;
    end else if (alloc) begin
      awvalid_reg <= 1'b1;
      wvalid_reg  <= 1'b1;
      awid_reg    <= ID_W'(alloc_id);
      awaddr_reg  <= req_reg.addr;
      w_reg       <= w_next;
    end else begin
      if (awvalid_reg && m_awready) awvalid_reg <= 1'b0;
      if (wvalid_reg && m_wready)   wvalid_reg  <= 1'b0;
    end
  end

  assign m_awid    = awid_reg;
  assign m_awaddr  = awaddr_reg;
  assign m_awlen   = 8'd0;
  assign m_awsize  = 3'(NB_LG);
  assign m_awburst = BURST_INCR;
  assign m_awvalid = awvalid_reg;
  assign m_wdata   = w_reg.data;
  assign m_wstrb   = w_reg.strb;
  assign m_wlast   = w_reg.last;
  assign m_wvalid  = wvalid_reg;
  assign m_bready  = 1'b1;
  assign credits   = credits_int;

  dma_resp_scoreboard #(
    .ID_W    (ID_W),
    .MAX_OUT (MAX_OUT)
  ) u_scoreboard (
    .clock       (clock),
    .RESETn      (RESETn),
    .alloc       (alloc),
    .alloc_id    (alloc_id),
    .credits     (credits_int),
    .m_bid       (m_bid),
    .m_bresp     (m_bresp),
    .m_bvalid    (m_bvalid),
    .s_bresp     (s_bresp),
    .s_bvalid    (s_bvalid),
    .s_bready    (s_bready),
    .err_unexp_b (err_unexp_b)
  );

endmodule

// File: tb/tb_dma_write_upsizer.sv
// Bench for dma_write_upsizer: table vectors, directed corner sequences and a
// randomized run checked against an issue-order reference model.
`timescale 1ns/1ps
module tb_dma_write_upsizer;
  import dma_pkg::*;

  localparam int N_RAND = 150;

  logic         clock = 1'b0;
  logic         RESETn = 1'b1;
  logic [48:0]  s_awaddr = '0;
  logic         s_awvalid = 1'b0, s_awready;
  logic [31:0]  s_wdata = '0;
  logic [3:0]   s_wstrb = '0;
  logic         s_wvalid = 1'b0, s_wready;
  logic [1:0]   s_bresp;
  logic         s_bvalid, s_bready = 1'b1;
  logic [5:0]   m_awid;
  logic [48:0]  m_awaddr;
  logic [7:0]   m_awlen;
  logic [2:0]   m_awsize;
  logic [1:0]   m_awburst;
  logic         m_awvalid, m_awready = 1'b1;
  logic [127:0] m_wdata;
  logic [15:0]  m_wstrb;
  logic         m_wlast, m_wvalid, m_wready = 1'b1;
  logic [5:0]   m_bid = '0;
  logic [1:0]   m_bresp = '0;
  logic         m_bvalid = 1'b0, m_bready;
  logic [4:0]   credits;
  logic         err_unexp_b;

  always #5 clock = ~clock;

  dma_write_upsizer dut (
    .clock(clock), .RESETn(RESETn),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready), .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid),
    .m_bready(m_bready), .credits(credits), .err_unexp_b(err_unexp_b)
  );

  typedef struct {
    logic [5:0]  id;
    logic [48:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } aw_rec_t;
  typedef struct {
    logic [127:0] data;
    logic [15:0]  strb;
    logic         last;
  } w_rec_t;
  typedef struct {
    logic [48:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [5:0]  exp_id;
    logic [15:0] exp_wstrb;
    logic [1:0]  resp;
  } vec_t;

  aw_rec_t    aw_q[$];
  w_rec_t     w_q[$];
  logic [1:0] db_q[$];
  int checks = 0;
  int failures = 0;

  // Passive monitor: every handshake on the M00 AW/W and DMA B channels.
  always @(posedge clock) begin
    if (RESETn) begin
      if (m_awvalid && m_awready) aw_q.push_back('{m_awid, m_awaddr, m_awlen, m_awsize, m_awburst});
      if (m_wvalid && m_wready)   w_q.push_back('{m_wdata, m_wstrb, m_wlast});
      if (s_bvalid && s_bready)   db_q.push_back(s_bresp);
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int qsize(input int which);
    case (which)
      0:       return aw_q.size();
      1:       return w_q.size();
      default: return db_q.size();
    endcase
  endfunction

  task automatic wait_count(input int which, input int n, input string name);
    int k = 0;
    while (qsize(which) < n && k < 500) begin
      tick();
      k++;
    end
    check(name, qsize(which), n);
  endtask

  function automatic logic [15:0] exp_strb(input logic [48:0] addr, input logic [3:0] strb);
    int lane_idx;
    lane_idx = int'((addr % 16) / 4);
    return 16'(strb) << (4 * lane_idx);
  endfunction

  task automatic do_reset();
    RESETn = 1'b0;
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b1;
    m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b0;
    aw_q.delete(); w_q.delete(); db_q.delete();
    tick(); tick();
    RESETn = 1'b1;
    tick();
  endtask

  task automatic send_write(input logic [48:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int  k = 0;
    logic aw_ok, w_ok;
    s_awaddr = addr; s_wdata = data; s_wstrb = strb;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    while ((s_awvalid || s_wvalid) && k < 2000) begin
      aw_ok = s_awvalid && s_awready;
      w_ok  = s_wvalid && s_wready;
      tick();
      if (aw_ok) s_awvalid = 1'b0;
      if (w_ok)  s_wvalid  = 1'b0;
      k++;
    end
    check("write_accepted", {s_awvalid, s_wvalid}, 2'b00);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
  endtask

  task automatic send_b(input logic [5:0] id, input logic [1:0] resp);
    m_bid = id; m_bresp = resp; m_bvalid = 1'b1;
    tick();
    m_bvalid = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[4];
  logic [1:0]  exp_resp[N_RAND];
  logic [48:0] sent_addr[$];
  logic [31:0] sent_data[$];
  logic [3:0]  sent_strb[$];

  initial begin
    vecs[0] = '{49'h0DE00,       32'hDEADBEEF, 4'hF, 6'd0, 16'h000F, RESP_OKAY};
    vecs[1] = '{49'h0DE0C,       32'h12345678, 4'h3, 6'd1, 16'h3000, RESP_OKAY};
    vecs[2] = '{49'h0DE04,       32'hA5A50F0F, 4'h5, 6'd2, 16'h0050, RESP_SLVERR};
    vecs[3] = '{49'h1_0000_0008, 32'hCAFEF00D, 4'hC, 6'd3, 16'h0C00, RESP_OKAY};

    // Reset values, sampled while reset is held.
    #1;
    RESETn = 1'b0;
    #3;
    check("rst_m_awvalid", m_awvalid, 0);
    check("rst_m_wvalid", m_wvalid, 0);
    check("rst_s_bvalid", s_bvalid, 0);
    check("rst_s_awready", s_awready, 1);
    check("rst_s_wready", s_wready, 1);
    check("rst_m_bready", m_bready, 1);
    check("rst_credits", credits, 16);
    check("rst_err", err_unexp_b, 0);
    do_reset();

    // Table-driven single writes with in-order responses.
    for (int i = 0; i < 4; i++) begin
      send_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
      wait_count(0, i + 1, "vec_aw_count");
      wait_count(1, i + 1, "vec_w_count");
      check("vec_awid", aw_q[i].id, vecs[i].exp_id);
      check("vec_awaddr", aw_q[i].addr, vecs[i].addr);
      check("vec_awlen", aw_q[i].len, 0);
      check("vec_awsize", aw_q[i].size, 2);
      check("vec_awburst", aw_q[i].burst, 1);
      check("vec_wdata", w_q[i].data, {vecs[i].data, vecs[i].data, vecs[i].data, vecs[i].data});
      check("vec_wstrb", w_q[i].strb, vecs[i].exp_wstrb);
      check("vec_wlast", w_q[i].last, 1);
      check("vec_credits_busy", credits, 15);
      send_b(vecs[i].exp_id, vecs[i].resp);
      wait_count(2, i + 1, "vec_db_count");
      check("vec_bresp", db_q[i], vecs[i].resp);
      check("vec_credits_idle", credits, 16);
      $display("vec %0d addr=0x%0h id=%0d wstrb=0x%04h bresp=%0d", i, vecs[i].addr,
               aw_q[i].id, w_q[i].strb, db_q[i]);
    end

    // AW five cycles ahead of W: one issue, one cycle after W capture.
    do_reset();
    s_awaddr = 49'h40; s_awvalid = 1'b1;
    tick();
    s_awvalid = 1'b0;
    repeat (5) tick();
    check("awfirst_no_issue", m_awvalid, 0);
    s_wdata = 32'h0BADF00D; s_wstrb = 4'hF; s_wvalid = 1'b1;
    tick();
    s_wvalid = 1'b0;
    check("awfirst_capture_cycle", m_awvalid, 0);
    tick();
    check("awfirst_awvalid", m_awvalid, 1);
    check("awfirst_wvalid", m_wvalid, 1);
    repeat (4) tick();
    check("awfirst_single_issue", aw_q.size(), 1);
    send_b(6'd0, RESP_OKAY);
    wait_count(2, 1, "awfirst_db");
    $display("awfirst id=%0d bresp=%0d", aw_q[0].id, db_q[0]);

    // Fill the ring with B held off, then wrap.
    do_reset();
    for (int i = 0; i < 16; i++) send_write(49'h1000 + 49'(i * 4), 32'(i), 4'hF);
    wait_count(0, 16, "full_aw_count");
    for (int i = 0; i < 16; i++) check("full_id", aw_q[i].id, 6'(i));
    check("full_credits", credits, 0);
    send_write(49'h2000, 32'h17, 4'hF);
    repeat (3) tick();
    check("full_17th_held", aw_q.size(), 16);
    s_awaddr = 49'h3000; s_wdata = 32'h18; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    repeat (3) tick();
    check("full_awready", s_awready, 0);
    check("full_wready", s_wready, 0);
    send_b(6'd0, RESP_OKAY);
    wait_count(2, 1, "full_db");
    wait_count(0, 17, "wrap_aw_count");
    check("wrap_id", aw_q[16].id, 0);
    check("wrap_addr", aw_q[16].addr, 49'h2000);
    repeat (2) tick();
    check("full_18th_stall", s_awready, 0);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    repeat (2) tick();
    check("full_18th_not_issued", aw_q.size(), 17);
    $display("wrap 17th id=%0d credits=%0d", aw_q[16].id, credits);

    // Out-of-order completions returned in issue order.
    do_reset();
    for (int i = 0; i < 3; i++) send_write(49'h500 + 49'(i * 4), 32'(100 + i), 4'hF);
    wait_count(0, 3, "ooo_aw_count");
    send_b(6'd2, RESP_OKAY);
    repeat (3) tick();
    check("ooo_hold_2", db_q.size(), 0);
    check("ooo_bvalid_low", s_bvalid, 0);
    send_b(6'd0, RESP_OKAY);
    wait_count(2, 1, "ooo_db0");
    repeat (3) tick();
    check("ooo_hold_2_after_0", db_q.size(), 1);
    send_b(6'd1, RESP_SLVERR);
    wait_count(2, 3, "ooo_db_all");
    check("ooo_resp0", db_q[0], RESP_OKAY);
    check("ooo_resp1", db_q[1], RESP_SLVERR);
    check("ooo_resp2", db_q[2], RESP_OKAY);
    check("ooo_credits", credits, 16);
    check("ooo_no_err", err_unexp_b, 0);
    $display("ooo dma b resps %0d %0d %0d", db_q[0], db_q[1], db_q[2]);

    // Unexpected B with nothing outstanding.
    send_b(6'd9, RESP_OKAY);
    check("unexp_err", err_unexp_b, 1);
    check("unexp_credits", credits, 16);
    repeat (2) tick();
    check("unexp_no_db", db_q.size(), 3);
    $display("unexpected bid=9 err=%0d", err_unexp_b);

    // Asynchronous reset while an issue is stalled on M00.
    do_reset();
    m_awready = 1'b0; m_wready = 1'b0;
    send_write(49'h700, 32'h77, 4'hF);
    tick(); tick();
    check("mid_awvalid_pre", m_awvalid, 1);
    check("mid_credits_pre", credits, 15);
    #2;
    RESETn = 1'b0;
    #1;
    check("mid_awvalid", m_awvalid, 0);
    check("mid_wvalid", m_wvalid, 0);
    check("mid_credits", credits, 16);
    check("mid_awready", s_awready, 1);
    do_reset();
    repeat (4) tick();
    check("mid_no_aw", aw_q.size(), 0);
    check("mid_no_bvalid", s_bvalid, 0);
    $display("reset mid-issue credits=%0d", credits);

    // Randomized traffic against an issue-order reference model.
    do_reset();
    fork
      begin : drv
        for (int k = 0; k < N_RAND; k++) begin
          logic [48:0] a;
          logic [31:0] d;
          logic [3:0]  s;
          a = {17'($urandom), $urandom};
          d = $urandom;
          s = 4'($urandom_range(1, 15));
          sent_addr.push_back(a); sent_data.push_back(d); sent_strb.push_back(s);
          send_write(a, d, s);
          repeat ($urandom_range(0, 3)) tick();
        end
      end
      begin : rsp
        int bsent = 0;
        int next_ready = 0;
        int cyc = 0;
        int pend[$];
        while (bsent < N_RAND && cyc < 30000) begin
          m_awready = ($urandom_range(0, 3) != 0);
          m_wready  = ($urandom_range(0, 3) != 0);
          s_bready  = ($urandom_range(0, 3) != 0);
          while (next_ready < aw_q.size() && next_ready < w_q.size()) begin
            pend.push_back(next_ready);
            next_ready++;
          end
          if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
            int j;
            int idx;
            j = $urandom_range(0, pend.size() - 1);
            idx = pend[j];
            pend.delete(j);
            exp_resp[idx] = ($urandom_range(0, 2) == 0) ? RESP_SLVERR : RESP_OKAY;
            m_bid = aw_q[idx].id; m_bresp = exp_resp[idx]; m_bvalid = 1'b1;
            bsent++;
          end else begin
            m_bvalid = 1'b0;
          end
          tick();
          cyc++;
        end
        m_bvalid = 1'b0; m_awready = 1'b1; m_wready = 1'b1; s_bready = 1'b1;
        check("rand_all_b_sent", bsent, N_RAND);
      end
    join
    wait_count(2, N_RAND, "rand_db_count");
    for (int k = 0; k < N_RAND; k++) begin
      check("rand_id", aw_q[k].id, 6'(k % 16));
      check("rand_addr", aw_q[k].addr, sent_addr[k]);
      check("rand_wdata", w_q[k].data, {sent_data[k], sent_data[k], sent_data[k], sent_data[k]});
      check("rand_wstrb", w_q[k].strb, exp_strb(sent_addr[k], sent_strb[k]));
      check("rand_bresp", db_q[k], exp_resp[k]);
    end
    check("rand_credits", credits, 16);
    check("rand_no_err", err_unexp_b, 0);
    $display("random run: %0d writes, %0d dma responses", N_RAND, db_q.size());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
